vram_scan_arbiter: RTL and testbench

- Owns the pixel-side port of the video memory dual-port BRAM, running on pxl_clk.
- Scan-out reads always win and keep their 1-cycle read latency.
- Secondary clients (blitter, sprite/cursor loader) get read/write bursts, but only inside blanking windows long enough to finish the whole burst.
- Sits between the VGA timing/address logic and BRAM port B.

---
 rtl/vram_arb_pkg.sv | 17 +
 rtl/vram_rr_picker.sv | 29 ++
 rtl/vram_scan_arbiter.sv | 135 +++++++++++++
 tb/tb_vram_scan_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the pixel-side VRAM arbiter.
package vram_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int LEN_W     = 4;
  localparam int MAX_BURST = 16;

  // Width of a client index; at least one bit even for a single client.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_rr_picker.sv
// Combinational round-robin selector: first set request after 'last'.
module vram_rr_picker
  import vram_arb_pkg::*;
#(
  parameter int N   = 2,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  // Scan clients starting one past the last winner, wrapping around.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (int'(last) + k) % N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/vram_scan_arbiter.sv
// Pixel-side BRAM port owner: scan-out reads always win, secondary
// clients get whole bursts only inside blanking windows that can hold them.
module vram_scan_arbiter #(
  parameter int ADDR_WIDTH  = 15,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLIENTS = 2,
  parameter int LEN_W       = 4
) (
  input  logic                              pxl_clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic                              disp_en,
  input  logic [ADDR_WIDTH-1:0]             disp_addr,
  output logic [DATA_WIDTH-1:0]             disp_rdata,
  input  logic [15:0]                       blank_left,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS*LEN_W-1:0]      cl_len,
  input  logic [NUM_CLIENTS*4-1:0]          cl_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]            cl_gnt,
  output logic [NUM_CLIENTS-1:0]            cl_beat,
  output logic [NUM_CLIENTS-1:0]            cl_rvalid,
  output logic [DATA_WIDTH-1:0]             cl_rdata,
  output logic                              bram_en,
  output logic [3:0]                        bram_we,
  output logic [ADDR_WIDTH-1:0]             bram_addr,
  output logic [DATA_WIDTH-1:0]             bram_wdata,
  input  logic [DATA_WIDTH-1:0]             bram_rdata
);
  import vram_arb_pkg::*;

  localparam int IDW = id_width(NUM_CLIENTS);

  arb_state_t             state_q, state_d;
  logic [IDW-1:0]         id_q, last_q, pick_idx;
  logic                   pick_valid;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [LEN_W-1:0]       len_q, beat_q;
  logic [3:0]             we_q;
  logic [NUM_CLIENTS-1:0] fit, rvalid_q;
  logic                   issue, last_beat;

  // Read data goes straight through, so scan-out latency equals the BRAM's.
  assign disp_rdata = bram_rdata;
  assign cl_rdata   = bram_rdata;
  assign cl_rvalid  = rvalid_q;

  // A beat issues whenever a burst is open and the display does not need the port.
  assign issue     = (state_q == BURST) && !disp_en;
  assign last_beat = (beat_q == len_q);

  // Burst fits if there is no window limit, or the remaining blanking exceeds its length.
  always_comb begin
    fit = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      fit[i] = !enable ||
               (!disp_en && ({1'b0, blank_left} > (17'(cl_len[i*LEN_W +: LEN_W]) + 17'd1)));
    end
  end

  vram_rr_picker #(
    .N   (NUM_CLIENTS),
    .IDW (IDW)
  ) u_picker (
    .req   (cl_req & fit),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: open a burst on a fitting grant, close it after the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = BURST;
      BURST:   if (issue && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst context, beat counter, round-robin pointer and registered read-valid.
  always_ff @(posedge pxl_clk or posedge rst) begin
    if (rst) begin
      id_q     <= '0;
      last_q   <= IDW'(NUM_CLIENTS - 1);
      base_q   <= '0;
      len_q    <= '0;
      we_q     <= '0;
      beat_q   <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= (issue && (we_q == 4'b0)) ? (NUM_CLIENTS'(1) << id_q) : '0;
      if (state_q == IDLE && pick_valid) begin
        id_q   <= pick_idx;
        base_q <= cl_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        len_q  <= cl_len[int'(pick_idx)*LEN_W +: LEN_W];
        we_q   <= cl_we[int'(pick_idx)*4 +: 4];
        beat_q <= '0;
      end else if (issue) begin
        beat_q <= beat_q + 1'b1;
        if (last_beat) last_q <= id_q;
      end
    end
  end

  // BRAM port mux and client handshakes: display first, then the active burst beat.
  always_comb begin
    bram_en    = 1'b0;
    bram_we    = '0;
    bram_addr  = '0;
    bram_wdata = '0;
    cl_gnt     = '0;
    cl_beat    = '0;
    if (disp_en) begin
      bram_en   = 1'b1;
      bram_addr = disp_addr;
    end else if (issue) begin
      bram_en     = 1'b1;
      bram_we     = we_q;
      bram_addr   = base_q + ADDR_WIDTH'(beat_q);
      bram_wdata  = cl_wdata[int'(id_q)*DATA_WIDTH +: DATA_WIDTH];
      cl_beat[id_q] = 1'b1;
      if (beat_q == '0) cl_gnt[id_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Directed bench for vram_scan_arbiter with a 1-cycle BRAM read stub.
module tb_vram_scan_arbiter;
  import vram_arb_pkg::*;

  logic        pxl_clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        disp_en;
  logic [14:0] disp_addr;
  logic [31:0] disp_rdata;
  logic [15:0] blank_left;
  logic [1:0]  cl_req;
  logic [7:0]  cl_len;
  logic [7:0]  cl_we;
  logic [29:0] cl_addr;
  logic [63:0] cl_wdata;
  logic [1:0]  cl_gnt, cl_beat, cl_rvalid;
  logic [31:0] cl_rdata;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [14:0] bram_addr;
  logic [31:0] bram_wdata;
  logic [31:0] bram_rdata = '0;

  int checks = 0;
  int errors = 0;

  vram_scan_arbiter dut (
    .pxl_clk    (pxl_clk),
    .rst        (rst),
    .enable     (enable),
    .disp_en    (disp_en),
    .disp_addr  (disp_addr),
    .disp_rdata (disp_rdata),
    .blank_left (blank_left),
    .cl_req     (cl_req),
    .cl_len     (cl_len),
    .cl_we      (cl_we),
    .cl_addr    (cl_addr),
    .cl_wdata   (cl_wdata),
    .cl_gnt     (cl_gnt),
    .cl_beat    (cl_beat),
    .cl_rvalid  (cl_rvalid),
    .cl_rdata   (cl_rdata),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .bram_rdata (bram_rdata)
  );

  always #5 pxl_clk = ~pxl_clk;

  // BRAM stub: read data is a tag OR'd with the address read, one cycle later.
  always @(posedge pxl_clk)
    if (bram_en && bram_we == 4'b0) bram_rdata <= 32'hAB00_0000 | 32'(bram_addr);

  task automatic tick();
    @(posedge pxl_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [14:0] wrap_addr [4];
  logic [31:0] wrap_data [4];

  initial begin
    wrap_addr[0] = 15'h7FFE; wrap_addr[1] = 15'h7FFF;
    wrap_addr[2] = 15'h0000; wrap_addr[3] = 15'h0001;
    wrap_data[0] = 32'hAB00_7FFE; wrap_data[1] = 32'hAB00_7FFF;
    wrap_data[2] = 32'hAB00_0000; wrap_data[3] = 32'hAB00_0001;

    // Reset with both clients requesting single-beat reads, no window limit.
    rst = 1'b1; enable = 1'b0; disp_en = 1'b0; disp_addr = '0; blank_left = '0;
    cl_req = 2'b11; cl_len = 8'h00; cl_we = 8'h00; cl_wdata = '0;
    cl_addr = {15'h0020, 15'h0010};
    tick(); tick();
    check("rst_bram_en", 64'(bram_en), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_bram_we", 64'(bram_we), 64'd0);
    check("rst_gnt", 64'(cl_gnt), 64'd0);
    check("rst_beat", 64'(cl_beat), 64'd0);
    check("rst_rvalid", 64'(cl_rvalid), 64'd0);
    check("rst_disp_rdata", 64'(disp_rdata), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'(IDLE));
    rst = 1'b0;

    // Round-robin: grants alternate 0,1,0,1 with an idle cycle between each.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt", 64'(cl_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_addr", 64'(bram_addr), (k % 2 == 0) ? 64'h10 : 64'h20);
      if (k == 3) cl_req = 2'b00;
      tick();
      check("rr_idle_gnt", 64'(cl_gnt), 64'd0);
      check("rr_idle_en", 64'(bram_en), 64'd0);
      check("rr_rvalid", 64'(cl_rvalid), (k % 2 == 0) ? 64'h1 : 64'h2);
      check("rr_rdata", 64'(cl_rdata), (k % 2 == 0) ? 64'hAB00_0010 : 64'hAB00_0020);
    end

    // Display priority over a pending client request.
    enable = 1'b1; disp_en = 1'b1; disp_addr = 15'h0123; blank_left = '0;
    cl_req = 2'b01; cl_addr[14:0] = 15'h0040;
    #1;
    check("disp_addr", 64'(bram_addr), 64'h0123);
    check("disp_en", 64'(bram_en), 64'd1);
    check("disp_we", 64'(bram_we), 64'd0);
    check("disp_gnt", 64'(cl_gnt), 64'd0);
    tick();
    check("disp_rdata", 64'(disp_rdata), 64'hAB00_0123);
    check("disp_state", 64'(dut.state_q), 64'(IDLE));
    // Withdrawn request is never granted even though it would fit.
    cl_req = 2'b00; disp_en = 1'b0; blank_left = 16'd50;
    tick();
    check("withdraw_state", 64'(dut.state_q), 64'(IDLE));
    check("withdraw_beat", 64'(cl_beat), 64'd0);

    // Fit: L=8 write burst needs blank_left > 8.
    cl_len[3:0] = 4'd7; cl_addr[14:0] = 15'h0100; cl_we[3:0] = 4'hF;
    cl_wdata[31:0] = 32'hD000_0000; cl_req = 2'b01; blank_left = 16'd8;
    tick();
    check("fit8_gnt", 64'(cl_gnt), 64'd0);
    check("fit8_state", 64'(dut.state_q), 64'(IDLE));
    blank_left = 16'd9;
    tick();
    check("fit9_gnt", 64'(cl_gnt), 64'h1);
    for (int b = 0; b < 8; b++) begin
      check("wr_beat", 64'(cl_beat), 64'h1);
      check("wr_addr", 64'(bram_addr), 64'h100 + 64'(b));
      check("wr_we", 64'(bram_we), 64'hF);
      check("wr_wdata", 64'(bram_wdata), 64'hD000_0000 + 64'(b));
      if (b == 0) cl_req = 2'b00;
      blank_left = blank_left - 16'd1;
      cl_wdata[31:0] = cl_wdata[31:0] + 32'd1;
      tick();
      check("wr_rvalid", 64'(cl_rvalid), 64'd0);
    end
    check("wr_done_beat", 64'(cl_beat), 64'd0);
    check("wr_done_state", 64'(dut.state_q), 64'(IDLE));
    check("wr_done_left", 64'(blank_left), 64'd1);

    // Read burst with address wrap for client 1.
    enable = 1'b0; blank_left = '0;
    cl_len[7:4] = 4'd3; cl_addr[29:15] = 15'h7FFE; cl_we[7:4] = 4'h0; cl_req = 2'b10;
    tick();
    for (int b = 0; b < 4; b++) begin
      check("wrap_gnt", 64'(cl_gnt), (b == 0) ? 64'h2 : 64'h0);
      check("wrap_beat", 64'(cl_beat), 64'h2);
      check("wrap_addr", 64'(bram_addr), 64'(wrap_addr[b]));
      if (b == 0) cl_req = 2'b00;
      tick();
      check("wrap_rvalid", 64'(cl_rvalid), 64'h2);
      check("wrap_rdata", 64'(cl_rdata), 64'(wrap_data[b]));
    end

    // Collision: display forced high at beat 2 for three cycles.
    enable = 1'b1; blank_left = 16'd20;
    cl_len[3:0] = 4'd5; cl_addr[14:0] = 15'h0200; cl_we[3:0] = 4'h0; cl_req = 2'b01;
    tick();
    check("col_gnt", 64'(cl_gnt), 64'h1);
    check("col_addr0", 64'(bram_addr), 64'h200);
    cl_req = 2'b00;
    tick();
    check("col_addr1", 64'(bram_addr), 64'h201);
    tick();
    disp_en = 1'b1; disp_addr = 15'h0555;
    #1;
    check("col_stall_beat", 64'(cl_beat), 64'd0);
    check("col_stall_addr", 64'(bram_addr), 64'h555);
    tick();
    check("col_stall_rvalid", 64'(cl_rvalid), 64'd0);
    check("col_stall2_beat", 64'(cl_beat), 64'd0);
    tick();
    check("col_stall3_beat", 64'(cl_beat), 64'd0);
    tick();
    disp_en = 1'b0;
    #1;
    check("col_resume_beat", 64'(cl_beat), 64'h1);
    check("col_resume_addr", 64'(bram_addr), 64'h202);
    check("col_resume_gnt", 64'(cl_gnt), 64'd0);
    tick();
    check("col_beat3_addr", 64'(bram_addr), 64'h203);
    check("col_beat3_rvalid", 64'(cl_rvalid), 64'h1);

    // Reset mid-burst: everything drops at once and stays quiet.
    rst = 1'b1;
    #1;
    check("mrst_en", 64'(bram_en), 64'd0);
    check("mrst_beat", 64'(cl_beat), 64'd0);
    check("mrst_rvalid", 64'(cl_rvalid), 64'd0);
    check("mrst_state", 64'(dut.state_q), 64'(IDLE));
    tick();
    check("mrst_hold_en", 64'(bram_en), 64'd0);
    rst = 1'b0;
    tick(); tick();
    check("post_rst_beat", 64'(cl_beat), 64'd0);
    check("post_rst_en", 64'(bram_en), 64'd0);
    check("post_rst_state", 64'(dut.state_q), 64'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
